sram_controller: RTL and testbench

- Processor-side initiator for the off-chip 16-bit asynchronous SRAM bus; it drives the pins that the SRAM model answers on.
- Sits in the MEM stage of the ARM pipeline.
- Turns one 32-bit load or store into two 16-bit SRAM half accesses: low half first, then high half.
- Holds `ready` low while an access is in flight so the pipeline freezes.

---
 rtl/sram_controller.sv | 162 ++++++++++++++++
 tb/tb_sram_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage initiator for a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half accesses (low half, then high half),
// each lasting ACCESS_CYCLES clocks, followed by a single DONE cycle.
// Optional build macro SRAM_WR_FWD_EN: forward the last completed store to a
// load of the same word without touching the SRAM.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  logic [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_op_wr;
    logic [16:0]      r_word;
    logic [31:0]      r_wdata;
    logic [15:0]      r_lo;
    logic [31:0]      r_rdata;

    logic             w_req;
    logic             w_hit;
    logic             w_start;
    logic             w_last;
    logic             w_dq_oe;
    logic [15:0]      w_dq_out;
    logic             w_unused;

    assign w_req    = wr_en | rd_en;
    assign w_start  = (r_state == IDLE) && w_req && !w_hit;
    assign w_last   = (r_cnt == CNT_LAST);
    assign SRAM_DQ  = w_dq_oe ? w_dq_out : 'z;
    assign w_unused = ^{address[31:19], address[1:0]};

`ifdef SRAM_WR_FWD_EN
    logic        r_fwd_valid;
    logic [16:0] r_fwd_tag;
    logic [31:0] r_fwd_data;

    assign w_hit     = (r_state == IDLE) && rd_en && !wr_en && r_fwd_valid
                       && (r_fwd_tag == address[18:2]);
    assign read_data = w_hit ? r_fwd_data : r_rdata;

    // Forwarding register: captures each store as it enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_tag   <= '0;
            r_fwd_data  <= '0;
        end else if (r_state == HIGH && w_last && r_op_wr) begin
            r_fwd_valid <= 1'b1;
            r_fwd_tag   <= r_word;
            r_fwd_data  <= r_wdata;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign read_data = r_rdata;
`endif

    // State and per-half cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request latch and read capture; low half is staged so read_data only
    // changes once the whole word has been read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_wr <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_op_wr <= wr_en;
                r_word  <= address[18:2];
                r_wdata <= write_data;
            end
            if (r_state == LOW && w_last && !r_op_wr)
                r_lo <= SRAM_DQ;
            if (r_state == HIGH && w_last && !r_op_wr)
                r_rdata <= {SRAM_DQ, r_lo};
`ifdef SRAM_WR_FWD_EN
            if (w_hit)
                r_rdata <= r_fwd_data;
`endif
        end
    end

    // Next state, counter and SRAM pin controls.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        ready      = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_CE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        w_dq_oe    = 1'b0;
        w_dq_out   = '0;
        unique case (r_state)
            IDLE: begin
                ready = !w_req || w_hit;
                if (w_start)
                    w_next = LOW;
            end
            LOW, HIGH: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_WE_N = !r_op_wr;
                SRAM_OE_N = r_op_wr;
                w_dq_oe   = r_op_wr;
                if (r_state == LOW) begin
                    SRAM_ADDR = {r_word, 1'b0};
                    w_dq_out  = r_wdata[15:0];
                end else begin
                    SRAM_ADDR = {r_word, 1'b1};
                    w_dq_out  = r_wdata[31:16];
                end
                if (w_last)
                    w_next = (r_state == LOW) ? HIGH : DONE;
                else
                    w_cnt_next = r_cnt + 1'b1;
            end
            DONE: begin
                ready  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench with a behavioural SRAM per DUT and a
// scoreboard of expected load results. Two DUTs: ACCESS_CYCLES=2 and =1.
module tb_sram_controller;

    localparam int AC0 = 2;

    logic        clk;
    logic        rst;

    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] dq0;
    logic [17:0] sa0;
    logic        ub0, lb0, we0, ce0, oe0;

    logic        wr_en1, rd_en1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1;
    wire  [15:0] dq1;
    logic [17:0] sa1;
    logic        ub1, lb1, we1, ce1, oe1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] exp_q [$];
    logic        fv;
    logic [16:0] ft;

    int n_assert = 0;
    int n_fail   = 0;

    sram_controller #(.ACCESS_CYCLES(AC0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_UB_N(ub0),
        .SRAM_LB_N(lb0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    sram_controller #(.ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_UB_N(ub1),
        .SRAM_LB_N(lb1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // Behavioural asynchronous SRAMs
    assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 'z;
    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 'z;

    always @(posedge clk) begin
        if (!ce0 && !we0) mem0[sa0] <= dq0;
        if (!ce1 && !we1) mem1[sa1] <= dq1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One DUT0 access starting in an IDLE cycle; checks pins every cycle.
    task automatic acc(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic hold);
        logic [16:0] w;
        logic        hit;
        logic [31:0] e;
        w   = a[18:2];
        hit = 1'b0;
        e   = '0;
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        if (wr) begin
            ref_mem[w] = d;
            fv = 1'b1;
            ft = w;
        end else begin
            exp_q.push_back(ref_mem.exists(w) ? ref_mem[w] : 32'h0);
`ifdef SRAM_WR_FWD_EN
            hit = fv && (ft == w);
`endif
        end
        #1;
        if (hit) begin
            e = exp_q.pop_front();
            chk("hit_ready_oe", {ready, oe0}, 2'b11);
            chk("hit_rdata", read_data, e);
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0; address = $urandom;
            #1;
            chk("hit_idle_pins", {ready, ce0, ub0, lb0, we0, oe0}, 6'b111111);
            chk("hit_rdata_hold", read_data, e);
            return;
        end
        chk("req_ready", ready, 1'b0);
        for (int k = 1; k <= 2 * AC0 + 1; k++) begin
            @(negedge clk);
            if (!hold && k == 1) begin
                wr_en = 1'b0; rd_en = 1'b0;
                address = $urandom; write_data = $urandom;
            end
            #1;
            if (k <= 2 * AC0) begin
                logic half;
                half = (k > AC0);
                chk("busy_pins", {ready, sa0, ce0, ub0, lb0, we0, oe0},
                    {1'b0, w, half, 3'b000, ~wr, wr});
                if (wr) chk("wr_dq", dq0, half ? d[31:16] : d[15:0]);
            end else begin
                chk("done_pins", {ready, ce0, ub0, lb0, we0, oe0}, 6'b111111);
                if (!wr) chk("rdata", read_data, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b0; fv = 1'b0; ft = '0;
        wr_en = 0; rd_en = 0; address = '0; write_data = '0;
        wr_en1 = 0; rd_en1 = 0; address1 = '0; write_data1 = '0;
        mem1[18'h210] = 16'h5678;
        mem1[18'h211] = 16'h1234;
        #12;
        chk("reset_pins", {ready, sa0, ce0, ub0, lb0, we0, oe0}, {1'b1, 18'h0, 5'b11111});
        chk("reset_rdata", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Write then read, back-to-back held stores, simultaneous request
        acc(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0);
        acc(1'b1, 1'b0, 32'h0000_0404, 32'h1111_2222, 1'b1);
        acc(1'b1, 1'b0, 32'h0000_0408, 32'h3333_4444, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_0408, 32'h0, 1'b0);
        acc(1'b1, 1'b1, 32'h0000_040C, 32'h0000_FFFF, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_040C, 32'h0, 1'b0);
        // Alias: bit 19 and above ignored
        acc(1'b0, 1'b1, 32'hFFF8_0400, 32'h0, 1'b0);

        // Reset during the high half of a read
        @(negedge clk);
        rd_en = 1'b1; address = 32'h0000_0408;
        #1 chk("rst_req_ready", ready, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst_in_high", {ready, sa0, oe0}, {1'b0, 18'h205, 1'b0});
        rst = 1'b0;
        fv  = 1'b0;
        #1;
        chk("abort_pins", {ready, sa0, ce0, ub0, lb0, we0, oe0}, {1'b1, 18'h0, 5'b11111});
        chk("abort_rdata", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        acc(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b0);

        // ACCESS_CYCLES=1 load
        @(negedge clk);
        rd_en1 = 1'b1; address1 = 32'h0000_0420;
        exp_q.push_back(32'h1234_5678);
        #1 chk("ac1_req_ready", ready1, 1'b0);
        @(negedge clk);
        rd_en1 = 1'b0; address1 = '0;
        #1 chk("ac1_low", {ready1, sa1, ce1, ub1, lb1, we1, oe1}, {1'b0, 18'h210, 5'b00010});
        @(negedge clk);
        #1 chk("ac1_high", {ready1, sa1, ce1, ub1, lb1, we1, oe1}, {1'b0, 18'h211, 5'b00010});
        @(negedge clk);
        #1 chk("ac1_done_ready", ready1, 1'b1);
        chk("ac1_rdata", read_data1, exp_q.pop_front());

        // Forwarded load (hit when the macro is defined) and a non-matching load
        acc(1'b1, 1'b0, 32'h0000_0414, 32'h55AA_55AA, 1'b0);
        acc(1'b1, 1'b0, 32'h0000_0410, 32'hCAFE_F00D, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_0410, 32'h0, 1'b0);
        acc(1'b0, 1'b1, 32'h0000_0414, 32'h0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
